// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage: data-bus FSM, load/store alignment, registered writeback bundle
//
// Purpose:
//   Takes the registered execute-stage bundle, performs loads and stores over
//   the data bus, and hands a registered result to writeback. While a bus
//   transaction is outstanding, mem_stall freezes fetch, decode and execute,
//   so ex_* stays stable and the request fields can be driven from it.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ex_valid                   ex_* holds a live instruction this cycle
//   ex_pc/instr/op/jump        execute bundle identity fields (passed through)
//   ex_regwrite/dst            register write enable and destination
//   ex_result                  ALU result / effective address
//   ex_memdata                 store data (right-aligned)
//   ex_memread/memwrite        load / store select
//   ex_msize                   access size: 0=B 1=H 2=W 3=D
//   ex_mem_unsigned            zero-extend loads when set
//   dreq_*                     data-bus request (valid, addr, size, strobe, data)
//   dresp_*                    data-bus response (addr_ok, data_ok, data)
//   mem_valid                  mem_* holds a live instruction
//   mem_pc/instr/op/jump       passed-through identity fields
//   mem_regwrite/dst/regdata   writeback controls and data
//   mem_addr                   effective address (ALU result)
//   mem_skip                   access hit the MMIO region
//   mem_stall                  upstream stages must hold

module mem_stage #(
    parameter int ADDR_MMIO_BIT = 31
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        ex_valid,
    input  logic [63:0] ex_pc,
    input  logic [31:0] ex_instr,
    input  logic [5:0]  ex_op,
    input  logic        ex_jump,
    input  logic        ex_regwrite,
    input  logic [4:0]  ex_dst,
    input  logic [63:0] ex_result,
    input  logic [63:0] ex_memdata,
    input  logic        ex_memread,
    input  logic        ex_memwrite,
    input  logic [1:0]  ex_msize,
    input  logic        ex_mem_unsigned,

    output logic        dreq_valid,
    output logic [63:0] dreq_addr,
    output logic [1:0]  dreq_size,
    output logic [7:0]  dreq_strobe,
    output logic [63:0] dreq_data,

    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [63:0] dresp_data,

    output logic        mem_valid,
    output logic [63:0] mem_pc,
    output logic [31:0] mem_instr,
    output logic [5:0]  mem_op,
    output logic        mem_jump,
    output logic        mem_regwrite,
    output logic [4:0]  mem_dst,
    output logic [63:0] mem_regdata,
    output logic [63:0] mem_addr,
    output logic        mem_skip,

    output logic        mem_stall
);

    localparam logic [1:0] MSIZE_B = 2'd0;
    localparam logic [1:0] MSIZE_H = 2'd1;
    localparam logic [1:0] MSIZE_W = 2'd2;
    localparam logic [1:0] MSIZE_D = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic        is_mem_op;
    logic        complete;
    logic [2:0]  byte_off;
    logic [5:0]  bit_off;
    logic [7:0]  base_mask;
    logic [63:0] load_shifted;
    logic [63:0] load_data;
    logic [63:0] result_data;
    logic        result_skip;

    // addr_ok is purely informational here; completion is judged by data_ok.
    logic unused_addr_ok;
    assign unused_addr_ok = dresp_addr_ok;

    assign is_mem_op = ex_valid & (ex_memread | ex_memwrite);
    assign byte_off  = ex_result[2:0];
    assign bit_off   = {byte_off, 3'b000};

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // dreq_valid rises in the same cycle the op arrives, so a zero-wait
    // device can answer with data_ok immediately and WAIT is skipped.
    // In WAIT the request stays up unconditionally: ex_* cannot change
    // because upstream is frozen by mem_stall.
    always_comb begin
        state_next = state;
        dreq_valid = 1'b0;
        mem_stall  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (is_mem_op) begin
                    dreq_valid = 1'b1;
                    if (dresp_data_ok) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_WAIT;
                        mem_stall  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                dreq_valid = 1'b1;
                if (dresp_data_ok) begin
                    state_next = ST_IDLE;
                end else begin
                    mem_stall  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request fields (driven from the held execute bundle)
    // ------------------------------------------------------------------
    always_comb begin
        base_mask = 8'h00;
        unique case (ex_msize)
            MSIZE_B: base_mask = 8'h01;
            MSIZE_H: base_mask = 8'h03;
            MSIZE_W: base_mask = 8'h0F;
            MSIZE_D: base_mask = 8'hFF;
            default: base_mask = 8'h00;
        endcase
    end

    assign dreq_addr   = ex_result;
    assign dreq_size   = ex_msize;
    assign dreq_data   = ex_memdata << bit_off;
    assign dreq_strobe = ex_memwrite ? (base_mask << byte_off) : 8'h00;

    // ------------------------------------------------------------------
    // Load alignment and extension
    // ------------------------------------------------------------------
    assign load_shifted = dresp_data >> bit_off;

    always_comb begin
        load_data = 64'd0;
        unique case (ex_msize)
            MSIZE_B: load_data = ex_mem_unsigned ? {56'd0, load_shifted[7:0]}
                                                 : {{56{load_shifted[7]}}, load_shifted[7:0]};
            MSIZE_H: load_data = ex_mem_unsigned ? {48'd0, load_shifted[15:0]}
                                                 : {{48{load_shifted[15]}}, load_shifted[15:0]};
            MSIZE_W: load_data = ex_mem_unsigned ? {32'd0, load_shifted[31:0]}
                                                 : {{32{load_shifted[31]}}, load_shifted[31:0]};
            MSIZE_D: load_data = load_shifted;
            default: load_data = 64'd0;
        endcase
    end

    // Stores write nothing back; non-memory ops forward the ALU result.
    always_comb begin
        result_data = ex_result;
        result_skip = 1'b0;
        if (ex_memread | ex_memwrite) begin
            result_data = ex_memread ? load_data : 64'd0;
            result_skip = ~ex_result[ADDR_MMIO_BIT];
        end
    end

    // An instruction retires from this stage either as a non-memory op
    // seen in IDLE, or as a memory op whose data_ok arrives.
    assign complete = ((state == ST_IDLE) & ex_valid & ~is_mem_op)
                    | (dreq_valid & dresp_data_ok);

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid    <= 1'b0;
            mem_pc       <= 64'd0;
            mem_instr    <= 32'd0;
            mem_op       <= 6'd0;
            mem_jump     <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_dst      <= 5'd0;
            mem_regdata  <= 64'd0;
            mem_addr     <= 64'd0;
            mem_skip     <= 1'b0;
        end else begin
            mem_valid <= complete;
            if (complete) begin
                mem_pc       <= ex_pc;
                mem_instr    <= ex_instr;
                mem_op       <= ex_op;
                mem_jump     <= ex_jump;
                mem_regwrite <= ex_regwrite;
                mem_dst      <= ex_dst;
                mem_regdata  <= result_data;
                mem_addr     <= ex_result;
                mem_skip     <= result_skip;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed scoreboard bench for mem_stage

module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [63:0] ex_pc;
    logic [31:0] ex_instr;
    logic [5:0]  ex_op;
    logic        ex_jump;
    logic        ex_regwrite;
    logic [4:0]  ex_dst;
    logic [63:0] ex_result;
    logic [63:0] ex_memdata;
    logic        ex_memread;
    logic        ex_memwrite;
    logic [1:0]  ex_msize;
    logic        ex_mem_unsigned;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        mem_valid;
    logic [63:0] mem_pc;
    logic [31:0] mem_instr;
    logic [5:0]  mem_op;
    logic        mem_jump;
    logic        mem_regwrite;
    logic [4:0]  mem_dst;
    logic [63:0] mem_regdata;
    logic [63:0] mem_addr;
    logic        mem_skip;
    logic        mem_stall;

    mem_stage #(.ADDR_MMIO_BIT(31)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_op(ex_op),
        .ex_jump(ex_jump), .ex_regwrite(ex_regwrite), .ex_dst(ex_dst),
        .ex_result(ex_result), .ex_memdata(ex_memdata), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_msize(ex_msize), .ex_mem_unsigned(ex_mem_unsigned),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_instr(mem_instr), .mem_op(mem_op),
        .mem_jump(mem_jump), .mem_regwrite(mem_regwrite), .mem_dst(mem_dst),
        .mem_regdata(mem_regdata), .mem_addr(mem_addr), .mem_skip(mem_skip),
        .mem_stall(mem_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  dst;
        logic [63:0] regdata;
        logic [63:0] addr;
        logic        regwrite;
        logic        skip;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Scoreboard: every retired instruction must match the oldest pending entry.
    always @(negedge clk) begin
        if (!reset && mem_valid) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("out_pc",       mem_pc,       e.pc);
                check("out_dst",      64'(mem_dst), 64'(e.dst));
                check("out_regdata",  mem_regdata,  e.regdata);
                check("out_addr",     mem_addr,     e.addr);
                check("out_regwrite", 64'(mem_regwrite), 64'(e.regwrite));
                check("out_skip",     64'(mem_skip),     64'(e.skip));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic idle_inputs();
        ex_valid = 0; ex_pc = 0; ex_instr = 0; ex_op = 0; ex_jump = 0;
        ex_regwrite = 0; ex_dst = 0; ex_result = 0; ex_memdata = 0;
        ex_memread = 0; ex_memwrite = 0; ex_msize = 0; ex_mem_unsigned = 0;
        dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = 0;
    endtask

    // Called just after a posedge. Holds the op until data_ok, which is
    // raised 'delay' cycles after the request first appears. Returns just
    // after the completing posedge with ex_* still driven.
    task automatic run_mem(input logic [63:0] pc, input logic wr, input logic [1:0] msize,
                           input logic uns, input logic [4:0] dst, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] rdata, input int delay,
                           input logic [7:0] exp_strobe, input logic [63:0] exp_wdata,
                           input logic [63:0] exp_regdata, input logic exp_mv0);
        exp_t e;
        int   stalls;
        ex_valid = 1; ex_pc = pc; ex_instr = 32'h3; ex_op = 6'd10; ex_jump = 0;
        ex_regwrite = ~wr; ex_dst = dst; ex_result = addr; ex_memdata = wdata;
        ex_memread = ~wr; ex_memwrite = wr; ex_msize = msize; ex_mem_unsigned = uns;
        dresp_data = rdata; dresp_data_ok = (delay == 0);
        dresp_addr_ok = 1;
        e.pc = pc; e.dst = dst; e.regdata = exp_regdata; e.addr = addr;
        e.regwrite = ~wr; e.skip = ~addr[31];
        sb.push_back(e);
        stalls = 0;
        for (int c = 0; c <= delay; c++) begin
            @(negedge clk);
            check("dreq_valid", 64'(dreq_valid), 64'd1);
            check("dreq_addr", dreq_addr, addr);
            check("dreq_size", 64'(dreq_size), 64'(msize));
            check("dreq_strobe", 64'(dreq_strobe), 64'(exp_strobe));
            if (wr) check("dreq_data", dreq_data, exp_wdata);
            check("mem_valid_during", 64'(mem_valid), (c == 0) ? 64'(exp_mv0) : 64'd0);
            if (mem_stall) stalls++;
            @(posedge clk); #1;
            dresp_addr_ok = 0;
            if (c + 1 == delay) dresp_data_ok = 1;
        end
        check("stall_cycles", 64'(stalls), 64'(delay));
    endtask

    // After an op completes with nothing queued behind it: one-cycle valid pulse.
    task automatic finish_op();
        idle_inputs();
        @(negedge clk);
        check("mem_valid_pulse", 64'(mem_valid), 64'd1);
        check("stall_after", 64'(mem_stall), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("mem_valid_drop", 64'(mem_valid), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_stall", 64'(mem_stall), 64'd0);
        check("rst_dreq_valid", 64'(dreq_valid), 64'd0);
        check("rst_regdata", mem_regdata, 64'd0);
        @(posedge clk); #1;

        // Reset while waiting on the bus abandons the transaction.
        ex_valid = 1; ex_memwrite = 1; ex_msize = 2'd3; ex_result = 64'h8000_0000;
        ex_memdata = 64'h55;
        @(posedge clk); #1;
        @(negedge clk);
        check("wait_dreq_valid", 64'(dreq_valid), 64'd1);
        check("wait_stall", 64'(mem_stall), 64'd1);
        reset = 1; ex_valid = 0; ex_memwrite = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("rstw_dreq_valid", 64'(dreq_valid), 64'd0);
        check("rstw_mem_valid", 64'(mem_valid), 64'd0);
        check("rstw_stall", 64'(mem_stall), 64'd0);
        dresp_data_ok = 1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstw_no_complete", 64'(mem_valid), 64'd0);
        dresp_data_ok = 0;
        @(posedge clk); #1;

        // ALU passthrough: result with bit31 clear must not set skip.
        begin
            exp_t e;
            ex_valid = 1; ex_pc = 64'h100; ex_instr = 32'h33; ex_op = 6'd1;
            ex_regwrite = 1; ex_dst = 5'd5; ex_result = 64'h1234;
            e.pc = 64'h100; e.dst = 5'd5; e.regdata = 64'h1234; e.addr = 64'h1234;
            e.regwrite = 1; e.skip = 0;
            sb.push_back(e);
            @(negedge clk);
            check("alu_stall", 64'(mem_stall), 64'd0);
            check("alu_no_dreq", 64'(dreq_valid), 64'd0);
            @(posedge clk); #1;
            finish_op();
        end

        // pc, wr, msize, uns, dst, addr, wdata, rdata, delay, strobe, exp wdata, exp regdata, mv0
        run_mem(64'h200, 0, 2'd0, 0, 5'd6, 64'h8000_0003, 64'd0, 64'h0000_0000_FF00_0000, 4,
                8'h00, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);                       // LB
        finish_op();
        run_mem(64'h204, 0, 2'd1, 1, 5'd7, 64'h8000_0006, 64'd0, 64'hABCD_0000_0000_0000, 0,
                8'h00, 64'd0, 64'h0000_0000_0000_ABCD, 0);                       // LHU
        finish_op();
        run_mem(64'h208, 1, 2'd2, 0, 5'd0, 64'h8000_0004, 64'hDEAD_BEEF, 64'd0, 2,
                8'hF0, 64'hDEAD_BEEF_0000_0000, 64'd0, 0);                       // SW
        finish_op();
        run_mem(64'h20C, 0, 2'd1, 0, 5'd8, 64'h8000_0002, 64'd0, 64'h0000_0000_8001_0000, 1,
                8'h00, 64'd0, 64'hFFFF_FFFF_FFFF_8001, 0);                       // LH
        finish_op();
        run_mem(64'h210, 1, 2'd0, 0, 5'd0, 64'h8000_0005, 64'h77, 64'd0, 0,
                8'h20, 64'h0000_7700_0000_0000, 64'd0, 0);                       // SB
        finish_op();
        run_mem(64'h214, 0, 2'd2, 0, 5'd9, 64'h8000_0000, 64'd0, 64'h0000_0000_8000_0000, 1,
                8'h00, 64'd0, 64'hFFFF_FFFF_8000_0000, 0);                       // LW
        finish_op();

        // MMIO LD followed by an immediately queued SD.
        run_mem(64'h300, 0, 2'd3, 0, 5'd10, 64'h4000_0000, 64'd0, 64'h1122_3344_5566_7788, 1,
                8'h00, 64'd0, 64'h1122_3344_5566_7788, 0);                       // LD
        run_mem(64'h304, 1, 2'd3, 0, 5'd0, 64'h4000_0008, 64'hCAFE_F00D_1234_5678, 64'd0, 1,
                8'hFF, 64'hCAFE_F00D_1234_5678, 64'd0, 1);                       // SD
        finish_op();

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
